seq_circuit_driver: RTL and testbench
=====================================

// Module: seq_circuit_driver
// PURPOSE
//  Initiator-side controller for a 2-bit up/down sequence circuit (A=0 -> count+1, A=1 -> count-1, mod 4; Y=1 iff count==2'b11).
//  Accepts target commands on a valid/ready port, drives A to steer the circuit's count to the target by the shortest path,
//  optionally dithers around it, and signals done. Keeps a shadow copy of the count and checks the circuit's Y against it.
// PARAMETERS
//  DW  4  width of cmd_dwell / dwell counter
// PORTS
//  clk        in   1   single clock; all state changes on posedge
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_target in   2   requested count value
//  cmd_dwell  in   DW  number of dither pairs once target reached (0 = none)
//  A          out  1   drive to the sequence circuit's A input
//  Y          in   1   sequence circuit's Y output (same cycle as the count it decodes)
//  shadow     out  2   mirrored count of the sequence circuit
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse; shadow==cmd_target in that cycle
//  err        out  1   sticky Y-mismatch flag
//  err_clr    in   1   clears err
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, shadow=2'b00, dither=0, dwell_cnt=0, phase=0, done=0, err=0; A=0, cmd_ready=1, busy=0.
//  Every posedge: shadow <= A ? shadow-1 : shadow+1 (mod 4; wraps 3->0 and 0->3). The circuit moves every cycle, so A is always meaningful.
//  A is combinational from state/registers. cmd_ready = (state==IDLE); accept in the done cycle allowed (back-to-back).
//  dither toggles every cycle (in any state).
//  diff = (tgt - shadow) mod 4, tgt = latched cmd_target.
//  FSM:
//   IDLE : A=dither (count oscillates). On accept: latch tgt, dwell_cnt<=cmd_dwell -> MOVE.
//   MOVE : A = (diff==3). diff 0 -> A=0 (step off, return next cycle); diff 2 -> A=0.
//          diff in {1,3}: final step; dwell_cnt==0 -> IDLE with done<=1; else -> DWELL with phase<=0.
//   DWELL: A=phase; phase toggles each cycle; on phase==1, dwell_cnt<=dwell_cnt-1; on phase==1 & dwell_cnt==1 -> IDLE, done<=1.
//          Count pattern: tgt+1, tgt, ... ending at tgt in the done cycle.
//  done registered, high exactly one cycle, which is the first IDLE cycle after completion; shadow==tgt in that cycle.
//  Latency from accept cycle to done: 1 + MOVE steps + 2*cmd_dwell cycles (MOVE steps 1 for diff 1/3, 2 for diff 0/2).
//  Error check (every cycle, rst_n=1): mismatch = Y ^ (shadow==2'b11). err <= mismatch | (err & ~err_clr); mismatch beats err_clr.
//  cmd_* ignored while busy. Reset mid-command aborts: no done, returns to reset values immediately.
// TESTING
//  1 Reset, cmd_valid=0 for 6 cycles -> A=0,1,0,1,0,1; shadow=0,1,0,1,0,1; Y consistent; err=0, busy=0.
//  2 Hold cmd_valid from reset release, target=3, dwell=0 (accept c0: shadow0,dither0) -> c1,c2 MOVE A=0,0; c3 done=1, shadow=3, Y=1.
//  3 Same start, target=2, dwell=2 -> c1 MOVE A=0; c2..c5 DWELL A=0,1,0,1 shadow 2,3,2,3; c6 done=1, shadow=2.
//  4 Same start, target=1, dwell=0 (diff 0 at c1) -> c1 A=0 shadow1, c2 A=1 shadow2, c3 done=1 shadow=1.
//  5 Force Y=1 while shadow=0 for one cycle -> err=1 next cycle, stays 1; pulse err_clr with Y correct -> err=0 next cycle.
//  6 Assert rst_n=0 during DWELL of test 3 -> outputs reset at once; no done; after release cmd_ready=1, shadow=0.

Source files
------------

// File: rtl/seq_circuit_driver.sv
// Steers a 2-bit up/down sequence circuit to a commanded count, optionally dithers around it, then pulses done.
// Latency: 1 + move steps (1 or 2) + 2*dwell cycles from accept to done; A is combinational from state.
// Backpressure: cmd_ready only while idle (including the done cycle); commands offered while busy are held off.
module seq_circuit_driver #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_target,
    input  logic [DW-1:0] cmd_dwell,
    output logic          A,
    input  logic          Y,
    output logic [1:0]    shadow,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          err_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    tgt, tgt_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic          dither;
    logic          phase, phase_nxt;
    logic          done_nxt;
    logic [1:0]    diff;
    logic          mismatch;

    assign diff      = tgt - shadow;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mismatch  = Y ^ (shadow == 2'b11);

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        dwell_nxt = dwell_cnt;
        phase_nxt = phase;
        done_nxt  = 1'b0;
        A         = 1'b0;
        case (state)
            IDLE: begin
                A = dither;
                if (cmd_valid) begin
                    tgt_nxt   = cmd_target;
                    dwell_nxt = cmd_dwell;
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                // odd distance is one step away; even distance steps up and lets the next cycle finish
                A = (diff == 2'd3);
                if (diff[0]) begin
                    if (dwell_cnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DWELL;
                        phase_nxt = 1'b0;
                    end
                end
            end
            DWELL: begin
                A         = phase;
                phase_nxt = ~phase;
                if (phase) begin
                    dwell_nxt = dwell_cnt - DW'(1);
                    if (dwell_cnt == DW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= 2'b00;
            dwell_cnt <= '0;
            phase     <= 1'b0;
            dither    <= 1'b0;
            shadow    <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            dwell_cnt <= dwell_nxt;
            phase     <= phase_nxt;
            dither    <= ~dither;
            shadow    <= A ? shadow - 2'd1 : shadow + 2'd1;
            done      <= done_nxt;
            err       <= mismatch | (err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_seq_circuit_driver.sv
// Bench for seq_circuit_driver: a modelled sequence circuit drives Y; table vectors, corner sequences and a randomized plan-based model.
module tb_seq_circuit_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_target;
    logic [3:0] cmd_dwell;
    logic       A;
    logic       Y;
    logic [1:0] shadow;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;

    logic [1:0] circ;
    logic       y_force;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_circuit_driver #(.DW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_dwell  (cmd_dwell),
        .A          (A),
        .Y          (Y),
        .shadow     (shadow),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr)
    );

    // the real sequence circuit the driver is steering
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) circ <= 2'b00;
        else        circ <= A ? circ - 2'd1 : circ + 2'd1;
    end
    assign Y = (circ == 2'b11) ^ y_force;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reset, then release at a negedge with the given command offered; returns in cycle c0
    task automatic start_cmd(input logic vld, input logic [1:0] t, input logic [3:0] d);
        rst_n      = 1'b0;
        cmd_valid  = vld;
        cmd_target = t;
        cmd_dwell  = d;
        err_clr    = 1'b0;
        y_force    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  tgt;
        logic [3:0]  dwell;
        int          lat;
        logic [15:0] a_seq;
    } vec_t;

    vec_t vecs[8];

    bit         plan[$];
    logic [1:0] m_cnt;
    logic       m_dith;
    logic       m_done;
    logic       exp_busy;
    logic       exp_a;
    logic       accept;
    logic [1:0] d;

    initial begin
        // accept at shadow 0 / dither 0, so the circuit sits at 1 in cycle c1
        vecs[0] = '{2'd3, 4'd0,  3, 16'h0000};
        vecs[1] = '{2'd2, 4'd2,  6, 16'h0014};
        vecs[2] = '{2'd1, 4'd0,  3, 16'h0002};
        vecs[3] = '{2'd0, 4'd0,  2, 16'h0001};
        vecs[4] = '{2'd0, 4'd1,  4, 16'h0005};
        vecs[5] = '{2'd3, 4'd3,  9, 16'h00A8};
        vecs[6] = '{2'd2, 4'd15, 32, 16'h5554};
        vecs[7] = '{2'd1, 4'd1,  5, 16'h000A};

        // reset state and free-running oscillation
        start_cmd(1'b0, 2'd0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_A", A, 0);
        chk("rst_shadow", shadow, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk("idle_A", A, i % 2);
            chk("idle_shadow", shadow, i % 2);
            chk("idle_busy", busy, 0);
            chk("idle_err", err, 0);
        end

        // table-driven commands accepted on the first cycle after reset
        foreach (vecs[v]) begin
            int got_lat;
            start_cmd(1'b1, vecs[v].tgt, vecs[v].dwell);
            chk("c0_ready", cmd_ready, 1);
            got_lat = -1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                if (done) begin
                    got_lat = i;
                    chk("done_shadow", shadow, vecs[v].tgt);
                    chk("done_ready", cmd_ready, 1);
                    break;
                end
                if (i <= 16) chk($sformatf("vec%0d_A_c%0d", v, i), A, vecs[v].a_seq[i-1]);
                chk("move_busy", busy, 1);
            end
            chk($sformatf("vec%0d_latency", v), got_lat, vecs[v].lat);
            @(negedge clk);
            chk("done_pulse_len", done, 0);
            chk("vec_err", err, 0);
        end

        // sticky error, clear, and mismatch winning over clear
        start_cmd(1'b0, 2'd0, 4'd0);
        if (shadow != 2'd0) @(negedge clk);
        y_force = 1'b1;
        @(negedge clk);
        y_force = 1'b0;
        chk("err_set", err, 1);
        @(negedge clk);
        chk("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", err, 0);
        err_clr = 1'b1;
        y_force = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        y_force = 1'b0;
        chk("err_beats_clr", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared2", err, 0);

        // reset in the middle of a dither
        start_cmd(1'b1, 2'd2, 4'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_A", A, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_shadow", shadow, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_rel_ready", cmd_ready, 1);
        chk("abort_rel_shadow", shadow, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        // randomized commands against a plan-of-steps model
        start_cmd(1'b0, 2'd0, 4'd0);
        m_cnt  = 2'd0;
        m_dith = 1'b0;
        m_done = 1'b0;
        plan.delete();
        for (int k = 0; k < 800; k++) begin
            if (k > 0) @(negedge clk);
            cmd_valid  = ($urandom_range(0, 2) == 0);
            cmd_target = 2'($urandom_range(0, 3));
            cmd_dwell  = 4'($urandom_range(0, 4));
            err_clr    = ($urandom_range(0, 7) == 0);
            exp_busy = (plan.size() != 0);
            exp_a    = exp_busy ? plan[0] : m_dith;
            chk("rnd_A", A, exp_a);
            chk("rnd_shadow", shadow, m_cnt);
            chk("rnd_busy", busy, exp_busy);
            chk("rnd_ready", cmd_ready, !exp_busy);
            chk("rnd_done", done, m_done);
            chk("rnd_err", err, 0);
            accept = !exp_busy && cmd_valid;
            m_cnt  = exp_a ? m_cnt - 2'd1 : m_cnt + 2'd1;
            m_dith = ~m_dith;
            m_done = 1'b0;
            if (exp_busy) begin
                void'(plan.pop_front());
                if (plan.size() == 0) m_done = 1'b1;
            end
            if (accept) begin
                d = cmd_target - m_cnt;
                case (d)
                    2'd1: plan.push_back(1'b0);
                    2'd3: plan.push_back(1'b1);
                    2'd2: begin plan.push_back(1'b0); plan.push_back(1'b0); end
                    default: begin plan.push_back(1'b0); plan.push_back(1'b1); end
                endcase
                for (int p = 0; p < int'(cmd_dwell); p++) begin
                    plan.push_back(1'b0);
                    plan.push_back(1'b1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
